// File: rtl/text_cursor_ctrl_if.sv
// Key-input / text-RAM-write bundle between a keyboard decoder, the cursor
// controller and the text RAM. The controller uses the slave view; whoever
// feeds keys and owns the display timing uses the master view.
interface text_cursor_ctrl_if;
    logic       key_valid;
    logic [5:0] key_code;
    logic       key_ready;
    logic       disp_busy;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [5:0] wr_data;
    logic [3:0] cursor_col;
    logic [1:0] cursor_row;
    logic       key_dropped;

    modport slave (
        input  key_valid, key_code, disp_busy,
        output key_ready, wr_en, wr_addr, wr_data,
               cursor_col, cursor_row, key_dropped
    );

    modport master (
        output key_valid, key_code, disp_busy,
        input  key_ready, wr_en, wr_addr, wr_data,
               cursor_col, cursor_row, key_dropped
    );
endinterface

// File: rtl/text_cursor_ctrl.sv
// Text cursor controller: turns decoded key strobes into text-RAM writes
// (print, backspace, full-screen clear) and tracks the cursor position.
// Writes are only ever issued while the display is not reading the RAM.
module text_cursor_ctrl #(
    parameter int         COLS  = 16,
    parameter int         ROWS  = 4,
    parameter logic [5:0] BLANK = 6'h00
) (
    input  logic              clk,
    input  logic              reset,
    text_cursor_ctrl_if.slave bus
);

    localparam logic [5:0] KEY_BS    = 6'h3D;
    localparam logic [5:0] KEY_ENTER = 6'h3E;
    localparam logic [5:0] KEY_CLEAR = 6'h3F;
    localparam logic [3:0] COL_LAST  = 4'(COLS - 1);
    localparam logic [1:0] ROW_LAST  = 2'(ROWS - 1);
    localparam logic [5:0] CELL_LAST = 6'(COLS * ROWS - 1);

    typedef enum logic [1:0] {IDLE, PEND_WR, CLEAR} state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] col;
    logic [1:0] row;
    // In PEND_WR this holds the latched target cell; in CLEAR it doubles as
    // the sweep counter, so wr_addr is always a plain register output.
    logic [5:0] addr;
    logic [5:0] data;
    logic       advance;
    logic       dropped;

    logic       ready;
    logic       write;
    logic       take_print;
    logic       take_bs;
    logic       take_enter;
    logic       take_clear;
    logic       at_origin;
    logic [5:0] inc_cursor;
    logic [5:0] dec_cursor;

    function automatic logic [5:0] cell_addr(input logic [1:0] r, input logic [3:0] c);
        return 6'(int'(r) * COLS + int'(c));
    endfunction

    function automatic logic [1:0] row_inc(input logic [1:0] r);
        return (r == ROW_LAST) ? 2'd0 : r + 2'd1;
    endfunction

    // Returns {row, col} one cell forward, wrapping the last cell to (0,0).
    function automatic logic [5:0] cursor_inc(input logic [1:0] r, input logic [3:0] c);
        if (c == COL_LAST) return {row_inc(r), 4'd0};
        return {r, c + 4'd1};
    endfunction

    // Returns {row, col} one cell back; only used when not at (0,0).
    function automatic logic [5:0] cursor_dec(input logic [1:0] r, input logic [3:0] c);
        if (c == 4'd0) return {r - 2'd1, COL_LAST};
        return {r, c - 4'd1};
    endfunction

    assign at_origin  = (row == 2'd0) && (col == 4'd0);
    assign inc_cursor = cursor_inc(row, col);
    assign dec_cursor = cursor_dec(row, col);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode, key acceptance and write strobe. The write enable is
    // qualified by the live disp_busy so a write can never overlap a display read.
    always_comb begin
        state_next = state;
        take_print = 1'b0;
        take_bs    = 1'b0;
        take_enter = 1'b0;
        take_clear = 1'b0;
        ready      = (state == IDLE);
        write      = (state != IDLE) && !bus.disp_busy;
        case (state)
            IDLE: begin
                if (bus.key_valid) begin
                    if (bus.key_code == KEY_BS) begin
                        if (!at_origin) begin
                            take_bs    = 1'b1;
                            state_next = PEND_WR;
                        end
                    end else if (bus.key_code == KEY_ENTER) begin
                        take_enter = 1'b1;
                    end else if (bus.key_code == KEY_CLEAR) begin
                        take_clear = 1'b1;
                        state_next = CLEAR;
                    end else begin
                        take_print = 1'b1;
                        state_next = PEND_WR;
                    end
                end
            end
            PEND_WR: begin
                if (write) state_next = IDLE;
            end
            CLEAR: begin
                if (write && addr == CELL_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Cursor, write address/data latches and the sticky dropped-key flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            col     <= 4'd0;
            row     <= 2'd0;
            addr    <= 6'd0;
            data    <= BLANK;
            advance <= 1'b0;
            dropped <= 1'b0;
        end else begin
            if (bus.key_valid && !ready) dropped <= 1'b1;

            if (take_print) begin
                data    <= bus.key_code;
                addr    <= cell_addr(row, col);
                advance <= 1'b1;
            end

            // Backspace moves the cursor first, then blanks the cell it lands on.
            if (take_bs) begin
                row     <= dec_cursor[5:4];
                col     <= dec_cursor[3:0];
                data    <= BLANK;
                addr    <= cell_addr(dec_cursor[5:4], dec_cursor[3:0]);
                advance <= 1'b0;
            end

            if (take_enter) begin
                col <= 4'd0;
                row <= row_inc(row);
            end

            if (take_clear) begin
                addr <= 6'd0;
                data <= BLANK;
            end

            if (state == PEND_WR && write && advance) begin
                row <= inc_cursor[5:4];
                col <= inc_cursor[3:0];
            end

            if (state == CLEAR && write) begin
                addr <= addr + 6'd1;
                if (addr == CELL_LAST) begin
                    col <= 4'd0;
                    row <= 2'd0;
                end
            end
        end
    end

    assign bus.key_ready   = ready;
    assign bus.wr_en       = write;
    assign bus.wr_addr     = addr;
    assign bus.wr_data     = data;
    assign bus.cursor_col  = col;
    assign bus.cursor_row  = row;
    assign bus.key_dropped = dropped;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed bench for text_cursor_ctrl: printing, busy stalls, backspace,
// enter, clear sweep, dropped keys and reset priority.
module tb_text_cursor_ctrl;

    localparam logic [5:0] TB_BLANK = 6'h20;

    logic clk;
    logic reset;
    int   checks;
    int   passed;

    text_cursor_ctrl_if bus();

    text_cursor_ctrl #(.COLS(16), .ROWS(4), .BLANK(TB_BLANK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.disp_busy = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic press_enter();
        bus.key_code  = 6'h3E;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic type_char(input logic [5:0] code);
        bus.key_code  = code;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 6'h00;
        bus.disp_busy = 1'b0;
        tick();
        tick();
        checks++; if (bus.key_ready !== 1'b1) $display("FAIL reset_key_ready: got %0b want 1", bus.key_ready); else passed++;
        checks++; if (bus.wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0b want 0", bus.wr_en); else passed++;
        checks++; if (bus.wr_addr !== 6'd0) $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); else passed++;
        checks++; if (bus.wr_data !== TB_BLANK) $display("FAIL reset_wr_data: got %h want %h", bus.wr_data, TB_BLANK); else passed++;
        checks++; if (bus.cursor_col !== 4'd0 || bus.cursor_row !== 2'd0) $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", bus.cursor_col, bus.cursor_row); else passed++;
        checks++; if (bus.key_dropped !== 1'b0) $display("FAIL reset_key_dropped: got %0b want 0", bus.key_dropped); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_print_basic();
        do_reset();
        bus.key_code  = 6'h05;
        bus.key_valid = 1'b1;
        #1;
        checks++; if (bus.wr_en !== 1'b0) $display("FAIL print_no_wr_in_key_cycle: got %0b want 0", bus.wr_en); else passed++;
        tick();
        bus.key_valid = 1'b0;
        #1;
        checks++; if (bus.wr_en !== 1'b1) $display("FAIL print_wr_en: got %0b want 1", bus.wr_en); else passed++;
        checks++; if (bus.wr_addr !== 6'd0) $display("FAIL print_wr_addr: got %0d want 0", bus.wr_addr); else passed++;
        checks++; if (bus.wr_data !== 6'h05) $display("FAIL print_wr_data: got %h want 05", bus.wr_data); else passed++;
        checks++; if (bus.key_ready !== 1'b0) $display("FAIL print_key_ready_pend: got %0b want 0", bus.key_ready); else passed++;
        tick();
        checks++; if (bus.wr_en !== 1'b0) $display("FAIL print_wr_en_after: got %0b want 0", bus.wr_en); else passed++;
        checks++; if (bus.cursor_col !== 4'd1 || bus.cursor_row !== 2'd0) $display("FAIL print_cursor: got (%0d,%0d) want (1,0)", bus.cursor_col, bus.cursor_row); else passed++;
        checks++; if (bus.key_ready !== 1'b1) $display("FAIL print_key_ready_idle: got %0b want 1", bus.key_ready); else passed++;
        checks++; if (bus.key_dropped !== 1'b0) $display("FAIL print_no_drop: got %0b want 0", bus.key_dropped); else passed++;
    endtask

    task automatic test_print_busy();
        int bad;
        do_reset();
        press_enter();
        press_enter();
        press_enter();
        for (int i = 0; i < 15; i++) type_char(6'(i + 1));
        checks++; if (bus.cursor_col !== 4'd15 || bus.cursor_row !== 2'd3) $display("FAIL busy_setup_cursor: got (%0d,%0d) want (15,3)", bus.cursor_col, bus.cursor_row); else passed++;
        bus.disp_busy = 1'b1;
        bus.key_code  = 6'h2A;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.wr_en !== 1'b0 || bus.key_ready !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad !== 0) $display("FAIL busy_hold: got %0d bad cycles want 0", bad); else passed++;
        bus.disp_busy = 1'b0;
        #1;
        checks++; if (bus.wr_en !== 1'b1) $display("FAIL busy_release_wr_en: got %0b want 1", bus.wr_en); else passed++;
        checks++; if (bus.wr_addr !== 6'd63) $display("FAIL busy_release_addr: got %0d want 63", bus.wr_addr); else passed++;
        checks++; if (bus.wr_data !== 6'h2A) $display("FAIL busy_release_data: got %h want 2a", bus.wr_data); else passed++;
        tick();
        checks++; if (bus.cursor_col !== 4'd0 || bus.cursor_row !== 2'd0) $display("FAIL busy_wrap_cursor: got (%0d,%0d) want (0,0)", bus.cursor_col, bus.cursor_row); else passed++;
        checks++; if (bus.wr_en !== 1'b0 || bus.key_ready !== 1'b1) $display("FAIL busy_back_idle: got wr_en=%0b ready=%0b want 0/1", bus.wr_en, bus.key_ready); else passed++;
    endtask

    task automatic test_backspace();
        int bad;
        do_reset();
        type_char(6'h11);
        press_enter();
        checks++; if (bus.cursor_col !== 4'd0 || bus.cursor_row !== 2'd1) $display("FAIL bs_setup_cursor: got (%0d,%0d) want (0,1)", bus.cursor_col, bus.cursor_row); else passed++;
        bus.key_code  = 6'h3D;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        #1;
        checks++; if (bus.wr_en !== 1'b1) $display("FAIL bs_wr_en: got %0b want 1", bus.wr_en); else passed++;
        checks++; if (bus.wr_addr !== 6'd15) $display("FAIL bs_wr_addr: got %0d want 15", bus.wr_addr); else passed++;
        checks++; if (bus.wr_data !== TB_BLANK) $display("FAIL bs_wr_data: got %h want %h", bus.wr_data, TB_BLANK); else passed++;
        checks++; if (bus.cursor_col !== 4'd15 || bus.cursor_row !== 2'd0) $display("FAIL bs_cursor: got (%0d,%0d) want (15,0)", bus.cursor_col, bus.cursor_row); else passed++;
        tick();
        checks++; if (bus.cursor_col !== 4'd15 || bus.cursor_row !== 2'd0 || bus.key_ready !== 1'b1) $display("FAIL bs_after: got (%0d,%0d) ready=%0b want (15,0) ready=1", bus.cursor_col, bus.cursor_row, bus.key_ready); else passed++;
        do_reset();
        bus.key_code  = 6'h3D;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.wr_en !== 1'b0 || bus.key_ready !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad !== 0) $display("FAIL bs_origin_ignored: got %0d bad cycles want 0", bad); else passed++;
        checks++; if (bus.cursor_col !== 4'd0 || bus.cursor_row !== 2'd0 || bus.key_dropped !== 1'b0) $display("FAIL bs_origin_cursor: got (%0d,%0d) drop=%0b want (0,0) drop=0", bus.cursor_col, bus.cursor_row, bus.key_dropped); else passed++;
    endtask

    task automatic test_enter();
        do_reset();
        press_enter();
        press_enter();
        press_enter();
        for (int i = 0; i < 7; i++) type_char(6'h30);
        checks++; if (bus.cursor_col !== 4'd7 || bus.cursor_row !== 2'd3) $display("FAIL enter_setup_cursor: got (%0d,%0d) want (7,3)", bus.cursor_col, bus.cursor_row); else passed++;
        bus.key_code  = 6'h3E;
        bus.key_valid = 1'b1;
        #1;
        checks++; if (bus.wr_en !== 1'b0) $display("FAIL enter_key_cycle_wr_en: got %0b want 0", bus.wr_en); else passed++;
        tick();
        bus.key_valid = 1'b0;
        #1;
        checks++; if (bus.cursor_col !== 4'd0 || bus.cursor_row !== 2'd0) $display("FAIL enter_cursor: got (%0d,%0d) want (0,0)", bus.cursor_col, bus.cursor_row); else passed++;
        checks++; if (bus.wr_en !== 1'b0 || bus.key_ready !== 1'b1) $display("FAIL enter_no_write: got wr_en=%0b ready=%0b want 0/1", bus.wr_en, bus.key_ready); else passed++;
    endtask

    task automatic test_clear();
        int  writes;
        int  errs;
        int  expect_addr;
        int  n_done;
        bit  done;
        writes      = 0;
        errs        = 0;
        expect_addr = 0;
        n_done      = -1;
        done        = 1'b0;
        type_char(6'h01);
        type_char(6'h02);
        type_char(6'h03);
        bus.disp_busy = 1'b0;
        bus.key_code  = 6'h3F;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bus.disp_busy = (n % 2 == 0);
            #1;
            if (bus.key_ready === 1'b1) begin
                done   = 1'b1;
                n_done = n;
                break;
            end
            if (bus.wr_en === 1'b1) begin
                if (bus.disp_busy) errs++;
                if (bus.wr_addr !== 6'(expect_addr) || bus.wr_data !== TB_BLANK) errs++;
                expect_addr++;
                writes++;
            end
            tick();
        end
        bus.disp_busy = 1'b0;
        checks++; if (done !== 1'b1) $display("FAIL clear_timeout: got done=%0b want 1", done); else passed++;
        checks++; if (writes !== 64) $display("FAIL clear_write_count: got %0d want 64", writes); else passed++;
        checks++; if (errs !== 0) $display("FAIL clear_write_sequence: got %0d errors want 0", errs); else passed++;
        checks++; if (n_done !== 128) $display("FAIL clear_duration: got %0d cycles want 128", n_done); else passed++;
        checks++; if (bus.cursor_col !== 4'd0 || bus.cursor_row !== 2'd0) $display("FAIL clear_cursor: got (%0d,%0d) want (0,0)", bus.cursor_col, bus.cursor_row); else passed++;
    endtask

    task automatic test_drop_mid_clear();
        int bad;
        do_reset();
        bus.key_code  = 6'h3F;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        tick();
        tick();
        checks++; if (bus.wr_addr !== 6'd2 || bus.key_dropped !== 1'b0) $display("FAIL mid_clear_progress: got addr=%0d drop=%0b want 2/0", bus.wr_addr, bus.key_dropped); else passed++;
        bus.key_code  = 6'h07;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        #1;
        checks++; if (bus.key_dropped !== 1'b1) $display("FAIL clear_key_dropped: got %0b want 1", bus.key_dropped); else passed++;
        checks++; if (bus.wr_addr !== 6'd3 || bus.wr_data !== TB_BLANK || bus.wr_en !== 1'b1) $display("FAIL clear_key_ignored: got addr=%0d data=%h en=%0b want 3/%h/1", bus.wr_addr, bus.wr_data, bus.wr_en, TB_BLANK); else passed++;
        checks++; if (bus.key_ready !== 1'b0) $display("FAIL clear_key_ready: got %0b want 0", bus.key_ready); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.key_ready !== 1'b1 || bus.wr_en !== 1'b0) $display("FAIL clear_reset_idle: got ready=%0b en=%0b want 1/0", bus.key_ready, bus.wr_en); else passed++;
        checks++; if (bus.key_dropped !== 1'b0) $display("FAIL clear_reset_dropped: got %0b want 0", bus.key_dropped); else passed++;
        checks++; if (bus.wr_addr !== 6'd0 || bus.wr_data !== TB_BLANK) $display("FAIL clear_reset_regs: got addr=%0d data=%h want 0/%h", bus.wr_addr, bus.wr_data, TB_BLANK); else passed++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.wr_en !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad !== 0) $display("FAIL clear_reset_abandoned: got %0d writes want 0", bad); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.disp_busy = 1'b1;
        bus.key_code  = 6'h09;
        bus.key_valid = 1'b1;
        tick();
        bus.key_code  = 6'h0A;
        tick();
        bus.key_valid = 1'b0;
        #1;
        checks++; if (bus.key_dropped !== 1'b1 || bus.key_ready !== 1'b0 || bus.wr_en !== 1'b0) $display("FAIL b2b_drop: got drop=%0b ready=%0b en=%0b want 1/0/0", bus.key_dropped, bus.key_ready, bus.wr_en); else passed++;
        bus.disp_busy = 1'b0;
        #1;
        checks++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 6'h09 || bus.wr_addr !== 6'd0) $display("FAIL b2b_first_key_kept: got en=%0b data=%h addr=%0d want 1/09/0", bus.wr_en, bus.wr_data, bus.wr_addr); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.wr_en !== 1'b0 || bus.key_ready !== 1'b1 || bus.key_dropped !== 1'b0) $display("FAIL pend_reset: got en=%0b ready=%0b drop=%0b want 0/1/0", bus.wr_en, bus.key_ready, bus.key_dropped); else passed++;
        checks++; if (bus.cursor_col !== 4'd0 || bus.cursor_row !== 2'd0) $display("FAIL pend_reset_cursor: got (%0d,%0d) want (0,0)", bus.cursor_col, bus.cursor_row); else passed++;
    endtask

    initial begin
        checks        = 0;
        passed        = 0;
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 6'h00;
        bus.disp_busy = 1'b0;
        test_reset();
        test_print_basic();
        test_print_busy();
        test_backspace();
        test_enter();
        test_clear();
        test_drop_mid_clear();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/text_cursor_ctrl.md
TEXT_CURSOR_CTRL -- requirements
Module: text_cursor_ctrl

Interface
REQ-001 The block SHALL have parameter COLS, default 16, meaning characters per text row (power of two).
REQ-002 The block SHALL have parameter ROWS, default 4, meaning text rows (power of two); COLS*ROWS = 64 cells.
REQ-003 The block SHALL have parameter BLANK, default 6'h00, meaning the character index written for an empty cell.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning pixel-domain clock (clkdiv4); the only clock.
REQ-005 The block SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-006 The block SHALL have port key_valid, input, 1 bit, meaning one-cycle strobe of a decoded key.
REQ-007 The block SHALL have port key_code, input, 6 bits, meaning character index; 6'h3D backspace, 6'h3E enter, 6'h3F clear, all others printable.
REQ-008 The block SHALL have port key_ready, output, 1 bit, meaning the controller accepts key_valid this cycle.
REQ-009 The block SHALL have port disp_busy, input, 1 bit, meaning the display is reading text RAM (display_area); no write is allowed.
REQ-010 The block SHALL have port wr_en, output, 1 bit, meaning text-RAM write strobe.
REQ-011 The block SHALL have port wr_addr, output, 6 bits, meaning cell address row*COLS+col.
REQ-012 The block SHALL have port wr_data, output, 6 bits, meaning character index to write.
REQ-013 The block SHALL have port cursor_col, output, 4 bits, meaning current cursor column.
REQ-014 The block SHALL have port cursor_row, output, 2 bits, meaning current cursor row.
REQ-015 The block SHALL have port key_dropped, output, 1 bit, meaning sticky flag: key_valid seen while key_ready=0.

Function
REQ-016 The FSM SHALL have three states: IDLE, PEND_WR and CLEAR; key_ready SHALL equal (state==IDLE), combinationally.
REQ-017 In IDLE, on a printable key_valid, the block SHALL latch data=key_code and addr=cursor, and go to PEND_WR with advance=1.
REQ-018 In IDLE, on a backspace with cursor != (0,0), the block SHALL decrement the cursor (col 0 -> col COLS-1 of the previous row), latch data=BLANK and addr=new cursor, and go to PEND_WR with advance=0.
REQ-019 A backspace at cursor (0,0) SHALL be ignored: no write, no state change.
REQ-020 An enter in IDLE SHALL set col=0 and row=(row+1) mod ROWS in the next cycle, with no write, and remain in IDLE.
REQ-021 A clear in IDLE SHALL reset the sweep counter to 0 and go to CLEAR.
REQ-022 In PEND_WR, wr_en SHALL be 1 only in a cycle with disp_busy=0, with wr_addr/wr_data being the latched values; the block SHALL stay in PEND_WR indefinitely while disp_busy=1.
REQ-023 In the cycle after a PEND_WR write, state SHALL be IDLE; if advance=1, the cursor SHALL increment col, and on col wrap SHALL increment row mod ROWS; (COLS-1,ROWS-1) SHALL wrap to (0,0).
REQ-024 In CLEAR, each cycle with disp_busy=0 SHALL write BLANK to the sweep address and increment it; after address 63 is written, the block SHALL set cursor=(0,0) and go to IDLE the next cycle.
REQ-025 wr_en SHALL be 0 in IDLE and whenever disp_busy=1; there SHALL be at most one write per cycle, registered output.
REQ-026 key_valid while key_ready=0 SHALL be discarded and SHALL set key_dropped=1 until reset; key_code SHALL be sampled only with key_valid=1 in IDLE.
REQ-027 Latency: the earliest write SHALL be one cycle after key_valid; cursor update SHALL occur one cycle after the write.

Reset
REQ-028 Reset SHALL take priority over all inputs, in any state including mid-CLEAR or PEND_WR.
REQ-029 On reset, the block SHALL set state=IDLE, key_ready=1, wr_en=0, wr_addr=0, wr_data=BLANK, cursor=(0,0), key_dropped=0 and sweep counter=0; any pending write SHALL be abandoned.

Verification
REQ-030 The bench SHALL cover printable 6'h05 at (0,0) with disp_busy=0 -> wr_en cycle+1, addr 0, data 05; cursor (1,0) at cycle+2.
REQ-031 The bench SHALL cover printable at (15,3) with disp_busy held 1 for 10 cycles -> no wr_en for 10 cycles, then write to addr 63, then cursor (0,0).
REQ-032 The bench SHALL cover backspace at (0,1) -> write BLANK to addr 15, cursor (15,0); backspace at (0,0) -> no write.
REQ-033 The bench SHALL cover clear with disp_busy toggling every cycle -> exactly 64 BLANK writes, addresses 0..63 in order, then cursor (0,0), key_ready=1.
REQ-034 The bench SHALL cover key_valid during CLEAR -> ignored and key_dropped=1; reset mid-CLEAR -> IDLE next cycle, wr_en=0, key_dropped=0.
REQ-035 The bench SHALL cover enter at (7,3) -> cursor (0,0), no wr_en.
